// File: rtl/hack_data_memory.sv
// rtl/hack_data_memory.sv - Hack CPU data memory responder: RAM, SCREEN shared with video scan-out, KBD register
// The CPU read is sampled READ_DELAY clocks after the strobe; video reads use SCREEN whenever the CPU does not.
module hack_data_memory #(
  parameter int READ_DELAY = 2,
  parameter int RAM_WORDS  = 16384,
  parameter int SCR_WORDS  = 8192
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        CPU_STROBE,
  input  logic [15:0] ADDRESS_M,
  input  logic [15:0] OUT_M,
  input  logic        LOAD_M,
  output logic [15:0] IN_M,
  input  logic        VID_REQ,
  input  logic [12:0] VID_ADDR,
  output logic        VID_ACK,
  output logic [15:0] VID_DATA,
  input  logic        KBD_VALID,
  input  logic [15:0] KBD_CODE,
  output logic        ADDR_ERR
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int SAW = $clog2(SCR_WORDS);
  localparam int CW  = $clog2(READ_DELAY + 1);

  typedef enum logic [1:0] {V_IDLE, V_RD, V_ACK} vid_state_t;
  typedef enum logic [1:0] {SEL_RAM, SEL_SCR, SEL_KBD, SEL_NONE} sel_t;

  logic [15:0]   r_ram [RAM_WORDS];
  logic [15:0]   r_scr [SCR_WORDS];
  logic [15:0]   r_ram_q;
  logic [15:0]   r_scr_q;
  logic [15:0]   r_kbd;
  logic [15:0]   r_kbd_q;
  logic [CW-1:0] r_rd_cnt;
  logic          r_rd_busy;
  logic          r_rd_pend;
  sel_t          r_rd_sel;
  vid_state_t    r_vid_state;

  sel_t           w_sel;
  logic           w_wr;
  logic           w_rd_slot;
  logic           w_slot_scr;
  logic           w_cpu_scr;
  logic           w_vid_issue;
  logic [SAW-1:0] w_scr_raddr;

  always_comb begin
    if (ADDRESS_M < 16'h4000)       w_sel = SEL_RAM;
    else if (ADDRESS_M < 16'h6000)  w_sel = SEL_SCR;
    else if (ADDRESS_M == 16'h6000) w_sel = SEL_KBD;
    else                            w_sel = SEL_NONE;
  end

  // A strobe landing on the sample clock restarts the count instead of sampling.
  assign w_wr        = CPU_STROBE & LOAD_M & ~RESET;
  assign w_rd_slot   = r_rd_busy & (r_rd_cnt == CW'(READ_DELAY)) & ~CPU_STROBE & ~RESET;
  assign w_slot_scr  = w_rd_slot & (w_sel == SEL_SCR);
  assign w_cpu_scr   = (w_wr & (w_sel == SEL_SCR)) | w_slot_scr;
  assign w_vid_issue = (r_vid_state == V_IDLE) & VID_REQ & ~w_cpu_scr & ~RESET;
  assign w_scr_raddr = w_slot_scr ? ADDRESS_M[SAW-1:0] : VID_ADDR[SAW-1:0];

  always_ff @(posedge CLK_100MHz) begin
    if (w_wr && w_sel == SEL_RAM) r_ram[ADDRESS_M[RAW-1:0]] <= OUT_M;
    if (w_rd_slot && w_sel == SEL_RAM) r_ram_q <= r_ram[ADDRESS_M[RAW-1:0]];
    if (w_wr && w_sel == SEL_SCR) r_scr[ADDRESS_M[SAW-1:0]] <= OUT_M;
    else if (w_slot_scr || w_vid_issue) r_scr_q <= r_scr[w_scr_raddr];
  end

  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      r_rd_busy   <= 1'b0;
      r_rd_cnt    <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_sel    <= SEL_NONE;
      r_kbd       <= '0;
      r_kbd_q     <= '0;
      IN_M        <= '0;
      ADDR_ERR    <= 1'b0;
      r_vid_state <= V_IDLE;
      VID_ACK     <= 1'b0;
      VID_DATA    <= '0;
    end else begin
      if (KBD_VALID) r_kbd <= KBD_CODE;

      if (CPU_STROBE) begin
        r_rd_busy <= 1'b1;
        r_rd_cnt  <= CW'(1);
      end else if (w_rd_slot) begin
        r_rd_busy <= 1'b0;
      end else if (r_rd_busy) begin
        r_rd_cnt  <= r_rd_cnt + CW'(1);
      end

      r_rd_pend <= w_rd_slot;
      if (w_rd_slot) begin
        r_rd_sel <= w_sel;
        r_kbd_q  <= r_kbd;
      end
      if (r_rd_pend) begin
        case (r_rd_sel)
          SEL_RAM: IN_M <= r_ram_q;
          SEL_SCR: IN_M <= r_scr_q;
          SEL_KBD: IN_M <= r_kbd_q;
          default: IN_M <= '0;
        endcase
      end

      if ((w_wr && (w_sel == SEL_KBD || w_sel == SEL_NONE)) || (w_rd_slot && w_sel == SEL_NONE))
        ADDR_ERR <= 1'b1;

      VID_ACK <= 1'b0;
      case (r_vid_state)
        V_IDLE: if (w_vid_issue) r_vid_state <= V_RD;
        V_RD: begin
          VID_DATA    <= r_scr_q;
          VID_ACK     <= 1'b1;
          r_vid_state <= V_ACK;
        end
        default: r_vid_state <= V_IDLE;
      endcase
    end
  end
endmodule
